// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU display stage: FSM states,
// active-low 7-segment codes (bit order gfedcba) and BCD helpers.
package alu_disp_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } disp_state_e;

    // One BCD digit is a nibble; three digits cover magnitudes up to 999
    localparam int BCD_W       = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_FIELD_W = BCD_W * BCD_DIGITS;

    // Special segment patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Segment codes for digits 0..9, entry [d] is the pattern for digit d
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Double-dabble correction: a nibble of 5 or more gets 3 added so that
    // the following left shift carries correctly into the next decade
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] nib);
        logic [BCD_W-1:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes above 9 are not decimal digits and show as a dash.
module bcd_to_seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Table lookup for legal digits, dash for anything else
    always_comb begin
        o_seg = SEG_DASH;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_DIGITS[i_digit];
        end else begin
            o_seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Display stage for the basic ALU: converts the A, B and C magnitudes to
// decimal one at a time with a shift-add-3 engine and presents all six
// digits on a single edge once the third value has been converted.
module seg_display_driver
    import alu_disp_pkg::*;
#(
    parameter int MAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [MAG_W-1:0] a_mag,
    input  logic [MAG_W-1:0] b_mag,
    input  logic [MAG_W-1:0] c_mag,
    output logic             busy,
    output logic             done,
    output logic [6:0]       gex_A1,
    output logic [6:0]       gex_A2,
    output logic [6:0]       gex_B1,
    output logic [6:0]       gex_B2,
    output logic [6:0]       gex_C1,
    output logic [6:0]       gex_C2
);

    // Shift register holds the BCD field above the binary magnitude
    localparam int SR_W = BCD_FIELD_W + MAG_W;
    localparam logic [3:0] CNT_INIT = 4'(MAG_W);

    disp_state_e r_state;
    disp_state_e w_state_nxt;

    logic [MAG_W-1:0] r_a;
    logic [MAG_W-1:0] r_b;
    logic [MAG_W-1:0] r_c;
    logic [1:0]       r_sel;
    logic [3:0]       r_cnt;
    logic [SR_W-1:0]  r_sreg;

    // Converted segment pairs {tens, ones} per value, published together
    logic [13:0] r_store_a;
    logic [13:0] r_store_b;
    logic [13:0] r_store_c;

    logic       r_busy;
    logic       r_done;
    logic [6:0] r_gex_a1;
    logic [6:0] r_gex_a2;
    logic [6:0] r_gex_b1;
    logic [6:0] r_gex_b2;
    logic [6:0] r_gex_c1;
    logic [6:0] r_gex_c2;

    logic [SR_W-1:0]  w_adjusted;
    logic [SR_W-1:0]  w_shifted;
    logic [3:0]       w_hund;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;
    logic [6:0]       w_seg_tens;
    logic [6:0]       w_seg_ones;
    logic [13:0]      w_pair;
    logic [MAG_W-1:0] w_next_mag;

    // Decoders shared by all three values; only the current one is decoded
    bcd_to_seg u_seg_tens (
        .i_digit (w_tens),
        .o_seg   (w_seg_tens)
    );

    bcd_to_seg u_seg_ones (
        .i_digit (w_ones),
        .o_seg   (w_seg_ones)
    );

    // One double-dabble step: correct each BCD nibble, then shift left by one
    always_comb begin
        w_adjusted = r_sreg;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            w_adjusted[MAG_W + BCD_W*k +: BCD_W] = bcd_adjust(r_sreg[MAG_W + BCD_W*k +: BCD_W]);
        end
        w_shifted = w_adjusted << 1;
    end

    // Split the finished BCD field and pick the segment pair to store,
    // blanking a leading zero and dashing values that need a hundreds digit
    always_comb begin
        w_hund = r_sreg[MAG_W + 2*BCD_W +: BCD_W];
        w_tens = r_sreg[MAG_W + BCD_W   +: BCD_W];
        w_ones = r_sreg[MAG_W           +: BCD_W];
        w_pair = {w_seg_tens, w_seg_ones};
        if (w_hund != 4'd0) begin
            w_pair = {SEG_DASH, SEG_DASH};
        end else if (w_tens == 4'd0) begin
            w_pair = {SEG_BLANK, w_seg_ones};
        end else begin
            w_pair = {w_seg_tens, w_seg_ones};
        end
    end

    // Magnitude to convert after the current one (B after A, C after B)
    always_comb begin
        w_next_mag = r_a;
        case (r_sel)
            2'd0:    w_next_mag = r_b;
            2'd1:    w_next_mag = r_c;
            default: w_next_mag = r_a;
        endcase
    end

    // Next-state logic for the conversion sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = STORE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            STORE: begin
                if (r_sel == 2'd2) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion datapath: capture, shift, and store per-value results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_sel     <= 2'd0;
            r_cnt     <= 4'd0;
            r_sreg    <= '0;
            r_store_a <= {SEG_BLANK, SEG_BLANK};
            r_store_b <= {SEG_BLANK, SEG_BLANK};
            r_store_c <= {SEG_BLANK, SEG_BLANK};
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_a    <= a_mag;
                        r_b    <= b_mag;
                        r_c    <= c_mag;
                        r_sel  <= 2'd0;
                        r_cnt  <= CNT_INIT;
                        r_sreg <= {{BCD_FIELD_W{1'b0}}, a_mag};
                    end
                end
                SHIFT: begin
                    r_sreg <= w_shifted;
                    r_cnt  <= r_cnt - 4'd1;
                end
                STORE: begin
                    case (r_sel)
                        2'd0:    r_store_a <= w_pair;
                        2'd1:    r_store_b <= w_pair;
                        default: r_store_c <= w_pair;
                    endcase
                    if (r_sel != 2'd2) begin
                        r_sel  <= r_sel + 2'd1;
                        r_cnt  <= CNT_INIT;
                        r_sreg <= {{BCD_FIELD_W{1'b0}}, w_next_mag};
                    end
                end
                DONE: begin
                    r_sel <= 2'd0;
                end
                default: begin
                    r_sel <= 2'd0;
                end
            endcase
        end
    end

    // Registered outputs: all six digits and the done pulse change together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gex_a1 <= SEG_BLANK;
            r_gex_a2 <= SEG_BLANK;
            r_gex_b1 <= SEG_BLANK;
            r_gex_b2 <= SEG_BLANK;
            r_gex_c1 <= SEG_BLANK;
            r_gex_c2 <= SEG_BLANK;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                {r_gex_a1, r_gex_a2} <= r_store_a;
                {r_gex_b1, r_gex_b2} <= r_store_b;
                {r_gex_c1, r_gex_c2} <= r_store_c;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign gex_A1 = r_gex_a1;
    assign gex_A2 = r_gex_a2;
    assign gex_B1 = r_gex_b1;
    assign gex_B2 = r_gex_b2;
    assign gex_C1 = r_gex_c1;
    assign gex_C2 = r_gex_c2;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: one instance at MAG_W=6 and
// one at MAG_W=8, each tracked by a decimal-arithmetic reference model.
module tb_seg_display_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       load6, load8;
    logic [5:0] a6, b6, c6;
    logic [7:0] a8, b8, c8;
    logic       busy6, done6, busy8, done8;
    logic [6:0] g6 [6];
    logic [6:0] g8 [6];

    seg_display_driver #(.MAG_W(6)) u_dut6 (
        .clk(clk), .reset(reset), .load(load6),
        .a_mag(a6), .b_mag(b6), .c_mag(c6),
        .busy(busy6), .done(done6),
        .gex_A1(g6[0]), .gex_A2(g6[1]), .gex_B1(g6[2]),
        .gex_B2(g6[3]), .gex_C1(g6[4]), .gex_C2(g6[5])
    );

    seg_display_driver #(.MAG_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .load(load8),
        .a_mag(a8), .b_mag(b8), .c_mag(c8),
        .busy(busy8), .done(done8),
        .gex_A1(g8[0]), .gex_A2(g8[1]), .gex_B1(g8[2]),
        .gex_B2(g8[3]), .gex_C1(g8[4]), .gex_C2(g8[5])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // Reference digit patterns straight from the display table
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {tens, ones} for a magnitude using plain decimal arithmetic
    function automatic logic [13:0] exp_pair(input int v);
        if (v >= 100)     return {7'h3F, 7'h3F};
        else if (v < 10)  return {7'h7F, seg_of(v)};
        else              return {seg_of(v / 10), seg_of(v % 10)};
    endfunction

    // Reference model: a busy countdown of the documented latency
    int          lat_of [2] = '{3*(6+1)+1, 3*(8+1)+1};
    int          m_cnt  [2] = '{0, 0};
    logic [13:0] m_pend [2][3];
    logic [6:0]  m_gex  [2][6];
    logic        m_done [2];
    logic        in_ld  [2];
    int          in_v   [2][3];

    assign in_ld[0] = load6;
    assign in_ld[1] = load8;
    assign in_v[0][0] = int'(a6);
    assign in_v[0][1] = int'(b6);
    assign in_v[0][2] = int'(c6);
    assign in_v[1][0] = int'(a8);
    assign in_v[1][1] = int'(b8);
    assign in_v[1][2] = int'(c8);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i]  <= 0;
                m_done[i] <= 1'b0;
                for (int j = 0; j < 6; j++) m_gex[i][j] <= 7'h7F;
            end else begin
                m_done[i] <= 1'b0;
                if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_done[i] <= 1'b1;
                        for (int j = 0; j < 3; j++) begin
                            m_gex[i][2*j]   <= m_pend[i][j][13:7];
                            m_gex[i][2*j+1] <= m_pend[i][j][6:0];
                        end
                    end
                end else if (in_ld[i]) begin
                    m_cnt[i] <= lat_of[i];
                    for (int j = 0; j < 3; j++) m_pend[i][j] <= exp_pair(in_v[i][j]);
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("w6.busy", {15'd0, busy6}, {15'd0, m_cnt[0] != 0});
            check("w6.done", {15'd0, done6}, {15'd0, m_done[0]});
            check("w8.busy", {15'd0, busy8}, {15'd0, m_cnt[1] != 0});
            check("w8.done", {15'd0, done8}, {15'd0, m_done[1]});
            for (int j = 0; j < 6; j++) begin
                check($sformatf("w6.gex%0d", j), {9'd0, g6[j]}, {9'd0, m_gex[0][j]});
                check($sformatf("w8.gex%0d", j), {9'd0, g8[j]}, {9'd0, m_gex[1][j]});
            end
        end
    end

    // Issue one load to the 6-bit instance and report edges until done
    task automatic run6(input int a, input int b, input int c, output int lat);
        load6 = 1'b1; a6 = 6'(a); b6 = 6'(b); c6 = 6'(c);
        @(negedge clk);
        load6 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done6 === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check6(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3,
                          input logic [6:0] e4, input logic [6:0] e5);
        check({nm, ".A1"}, {9'd0, g6[0]}, {9'd0, e0});
        check({nm, ".A2"}, {9'd0, g6[1]}, {9'd0, e1});
        check({nm, ".B1"}, {9'd0, g6[2]}, {9'd0, e2});
        check({nm, ".B2"}, {9'd0, g6[3]}, {9'd0, e3});
        check({nm, ".C1"}, {9'd0, g6[4]}, {9'd0, e4});
        check({nm, ".C2"}, {9'd0, g6[5]}, {9'd0, e5});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ndone;
        reset = 1'b1;
        load6 = 1'b1; a6 = 6'd7; b6 = 6'd7; c6 = 6'd7;
        load8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        load6 = 1'b0;
        chk_en = 1'b1;
        check6("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("rst.busy", {15'd0, busy6}, 16'd0);
        check("rst.done", {15'd0, done6}, 16'd0);
        @(negedge clk);
        check("rst.load_ignored", {15'd0, busy6}, 16'd0);

        // Basic conversion and latency
        run6(29, 5, 34, lat);
        check("basic.latency", 16'(lat), 16'd22);
        check6("basic", 7'h24, 7'h10, 7'h7F, 7'h12, 7'h30, 7'h19);
        @(negedge clk);
        check("basic.done_single", {15'd0, done6}, 16'd0);
        check("basic.busy_after", {15'd0, busy6}, 16'd0);

        // Boundaries: zero, all-ones, exact ten
        run6(0, 63, 10, lat);
        check("bound.latency", 16'(lat), 16'd22);
        check6("bound", 7'h7F, 7'h40, 7'h02, 7'h30, 7'h79, 7'h40);
        @(negedge clk);

        // Load while busy is dropped
        load6 = 1'b1; a6 = 6'd1; b6 = 6'd2; c6 = 6'd3;
        @(negedge clk);
        load6 = 1'b0;
        repeat (4) @(negedge clk);
        load6 = 1'b1; a6 = 6'd9; b6 = 6'd9; c6 = 6'd9;
        @(negedge clk);
        load6 = 1'b0;
        ndone = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done6 === 1'b1) ndone++;
        end
        check("busyload.done_count", 16'(ndone), 16'd1);
        check6("busyload", 7'h7F, 7'h79, 7'h7F, 7'h24, 7'h7F, 7'h30);

        // Reset in the middle of a conversion
        load6 = 1'b1; a6 = 6'd12; b6 = 6'd34; c6 = 6'd46;
        @(negedge clk);
        load6 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.busy", {15'd0, busy6}, 16'd0);
        check6("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done6 === 1'b1) ndone++;
        end
        check("midrst.no_done", 16'(ndone), 16'd0);
        run6(12, 34, 46, lat);
        check("reload.latency", 16'(lat), 16'd22);
        check6("reload", 7'h79, 7'h24, 7'h30, 7'h19, 7'h19, 7'h02);
        @(negedge clk);

        // Wider instance: hundreds show dashes
        load8 = 1'b1; a8 = 8'd100; b8 = 8'd99; c8 = 8'd255;
        @(negedge clk);
        load8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("w8.latency", 16'(lat), 16'd28);
        check("w8.A1", {9'd0, g8[0]}, 16'h003F);
        check("w8.A2", {9'd0, g8[1]}, 16'h003F);
        check("w8.B1", {9'd0, g8[2]}, 16'h0010);
        check("w8.B2", {9'd0, g8[3]}, 16'h0010);
        check("w8.C1", {9'd0, g8[4]}, 16'h003F);
        check("w8.C2", {9'd0, g8[5]}, 16'h003F);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
